// File: rtl/syn_pcm_mem_ctrl.sv
// PCM sample RAM sequencer between Acortex (writer) and Fgyrus (reader).
// Fills one frame, hands the RAM to Fgyrus until done, counts dropped samples.
//
// Ports:
//   clk_ir, rst_il        clock, async active-low reset
//   cap_en                capture enable (checked at frame boundaries)
//   acx_valid/lpcm/rpcm   Acortex stereo sample strobe and data
//   fgy_rd_req/raddr      Fgyrus read request and address
//   fgy_done              Fgyrus releases the frame (1-cycle pulse)
//   fgy_lpcm/rpcm         read data, qualified by fgy_rd_valid
//   fgy_rd_valid/rd_addr  read data valid and its address
//   pcm_data_rdy          frame complete, Fgyrus owns the RAM
//   pcm_addr/wren/rden    RAM address and strobes
//   lpcm/rpcm_wdata       RAM write data
//   lpcm/rpcm_rdata       RAM read data (RD_DELAY clocks after pcm_rden)
//   ovf_cnt               saturating count of samples dropped in READY
module syn_pcm_mem_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 7,
    parameter int RD_DELAY = 2
) (
    input  logic              clk_ir,
    input  logic              rst_il,
    input  logic              cap_en,
    input  logic              acx_valid,
    input  logic [DATA_W-1:0] acx_lpcm,
    input  logic [DATA_W-1:0] acx_rpcm,
    input  logic              fgy_rd_req,
    input  logic [ADDR_W-1:0] fgy_raddr,
    input  logic              fgy_done,
    output logic [DATA_W-1:0] fgy_lpcm,
    output logic [DATA_W-1:0] fgy_rpcm,
    output logic              fgy_rd_valid,
    output logic [ADDR_W-1:0] fgy_rd_addr,
    output logic              pcm_data_rdy,
    output logic [ADDR_W-1:0] pcm_addr,
    output logic [DATA_W-1:0] lpcm_wdata,
    output logic [DATA_W-1:0] rpcm_wdata,
    output logic              pcm_wren,
    output logic              pcm_rden,
    input  logic [DATA_W-1:0] lpcm_rdata,
    input  logic [DATA_W-1:0] rpcm_rdata,
    output logic [15:0]       ovf_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_READY
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t              state;
    logic [ADDR_W-1:0]   wptr;
    logic [RD_DELAY-1:0] vld_pipe;
    logic [ADDR_W-1:0]   addr_pipe [RD_DELAY];

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state        <= ST_IDLE;
            wptr         <= '0;
            pcm_wren     <= 1'b0;
            pcm_rden     <= 1'b0;
            pcm_addr     <= '0;
            lpcm_wdata   <= '0;
            rpcm_wdata   <= '0;
            pcm_data_rdy <= 1'b0;
            ovf_cnt      <= '0;
            vld_pipe     <= '0;
            for (int i = 0; i < RD_DELAY; i++) begin
                addr_pipe[i] <= '0;
            end
        end else begin
            pcm_wren     <= 1'b0;
            pcm_rden     <= 1'b0;
            pcm_data_rdy <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cap_en) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (acx_valid) begin
                        pcm_wren   <= 1'b1;
                        pcm_addr   <= wptr;
                        lpcm_wdata <= acx_lpcm;
                        rpcm_wdata <= acx_rpcm;
                        wptr       <= wptr + ADDR_W'(1);
                        if (wptr == LAST) begin
                            state <= ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    // Ready flag trails READY entry by one clock so it
                    // appears after the final write has been presented.
                    pcm_data_rdy <= !fgy_done;
                    if (fgy_rd_req) begin
                        pcm_rden <= 1'b1;
                        pcm_addr <= fgy_raddr;
                    end
                    if (acx_valid && ovf_cnt != 16'hFFFF) begin
                        ovf_cnt <= ovf_cnt + 16'd1;
                    end
                    if (fgy_done) begin
                        state <= cap_en ? ST_CAPTURE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Read tracking runs in every state so reads issued
            // before fgy_done still drain.
            vld_pipe[0]  <= pcm_rden;
            addr_pipe[0] <= pcm_addr;
            for (int i = 1; i < RD_DELAY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign fgy_rd_valid = vld_pipe[RD_DELAY-1];
    assign fgy_rd_addr  = addr_pipe[RD_DELAY-1];
    assign fgy_lpcm     = fgy_rd_valid ? lpcm_rdata : '0;
    assign fgy_rpcm     = fgy_rd_valid ? rpcm_rdata : '0;

endmodule
